uart_tx_feeder: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_feeder_if.sv | 30 +++
 rtl/uart_fifo_mem.sv | 48 ++++
 rtl/uart_tx_feeder.sv | 68 ++++++
 tb/tb_uart_tx_feeder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM states and the default byte width,
// so the feeder and the transmitter agree on DataWidth.
package uart_pkg;
  localparam int UartDataWidth = 8;

  typedef enum logic [1:0] {
    Ready = 2'd0,
    Issue = 2'd1,
    Drain = 2'd2
  } feeder_state_e;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bus-side push port, status flags and transmitter dv/busy handshake of the TX feeder.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DataWidth = UartDataWidth,
  parameter int Depth     = 16
);
  localparam int LevelWidth = $clog2(Depth) + 1;

  logic                  wr_en_i;
  logic [DataWidth-1:0]  wr_data_i;
  logic                  full_o;
  logic                  empty_o;
  logic [LevelWidth-1:0] level_o;
  logic                  overflow_o;
  logic                  clr_ovf_i;
  logic                  tx_dv_o;
  logic [DataWidth-1:0]  tx_data_o;
  logic                  tx_busy_i;

  // master drives the bus side and the transmitter busy; slave is the feeder
  modport master (
    output wr_en_i, wr_data_i, clr_ovf_i, tx_busy_i,
    input  full_o, empty_o, level_o, overflow_o, tx_dv_o, tx_data_o
  );
  modport slave (
    input  wr_en_i, wr_data_i, clr_ovf_i, tx_busy_i,
    output full_o, empty_o, level_o, overflow_o, tx_dv_o, tx_data_o
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Circular-buffer byte FIFO: storage, wrapping pointers, occupancy level and flags.
// Callers must not push when full nor pop when empty.
module uart_fifo_mem #(
  parameter  int DataWidth  = 8,
  parameter  int Depth      = 16,
  localparam int AddrWidth  = $clog2(Depth),
  localparam int LevelWidth = $clog2(Depth) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DataWidth-1:0]  wr_data_i,
  input  logic                  pop_i,
  output logic [DataWidth-1:0]  rd_data_o,
  output logic [LevelWidth-1:0] level_o,
  output logic                  full_o,
  output logic                  empty_o
);
  logic [DataWidth-1:0]  mem [Depth];
  logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelWidth-1:0] level_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= wr_data_i;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LevelWidth'(1);
        2'b01:   level_q <= level_q - LevelWidth'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign level_o   = level_q;
  assign full_o    = (level_q == LevelWidth'(Depth));
  assign empty_o   = (level_q == '0);
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bus-side bytes and issues them one per frame to the UART transmitter
// over its dv/busy handshake; tracks a sticky overflow flag for dropped pushes.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DataWidth = UartDataWidth,
  parameter int Depth     = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  uart_tx_feeder_if.slave  bus
);
  localparam int LevelWidth = $clog2(Depth) + 1;

  feeder_state_e         state_q, state_d;
  logic                  push, pop, full, empty, ovf_q;
  logic [DataWidth-1:0]  head;
  logic [LevelWidth-1:0] level;

  assign push = bus.wr_en_i & ~full;
  assign pop  = (state_q == Issue);

  uart_fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .wr_data_i (bus.wr_data_i),
    .pop_i     (pop),
    .rd_data_o (head),
    .level_o   (level),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Ready;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.wr_en_i && full) ovf_q <= 1'b1;
      else if (bus.clr_ovf_i)  ovf_q <= 1'b0;
    end
  end

  // Drain holds off until busy drops; the transmitter raises busy in the
  // issue cycle, so a byte is never issued twice into the same frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Ready:   if (!empty && !bus.tx_busy_i) state_d = Issue;
      Issue:   state_d = Drain;
      Drain:   if (!bus.tx_busy_i) state_d = Ready;
      default: state_d = Ready;
    endcase
  end

  // dv is a pure state decode so there is no path from tx_busy_i back to tx_dv_o
  assign bus.tx_dv_o    = (state_q == Issue);
  assign bus.tx_data_o  = (state_q == Issue) ? head : '0;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.level_o    = level;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter busy model.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DataWidth(DW), .Depth(DEPTH)) bus ();

  uart_tx_feeder #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // transmitter model: busy rises with dv and lasts frame_len cycles in total
  logic force_busy = 1'b0;
  int   frame_len  = 50;
  int   cnt        = 0;
  int   cyc        = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)                cnt <= 0;
    else if (bus.tx_dv_o)   cnt <= frame_len - 1;
    else if (cnt != 0)      cnt <= cnt - 1;
  end
  assign bus.tx_busy_i = force_busy | bus.tx_dv_o | (cnt != 0);

  // monitor: collect issued bytes, check dv spacing after busy falls
  logic [7:0] got[$];
  int         dv_cyc[$];
  logic       busy_prev = 1'b0;
  int         fall_cyc  = -1;
  bit         chk_gap   = 1'b0;
  int         gap_from  = 0;

  always @(negedge clk) begin
    if (bus.tx_dv_o) begin
      got.push_back(bus.tx_data_o);
      dv_cyc.push_back(cyc);
      if (chk_gap && fall_cyc >= gap_from) chk("burst_gap", cyc - fall_cyc, 2);
    end
    if (busy_prev && !bus.tx_busy_i) fall_cyc <= cyc;
    busy_prev <= bus.tx_busy_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_items(input string tag, input int n, input int budget);
    int t = 0;
    while (got.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (got.size() < n) chk(tag, got.size(), n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.tx_busy_i || !bus.empty_o) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (bus.tx_busy_i || !bus.empty_o) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int c, base;
    bus.wr_en_i   = 1'b0;
    bus.wr_data_i = '0;
    bus.clr_ovf_i = 1'b0;

    // 1: reset then idle
    @(negedge clk);
    chk("rst_state", {bus.tx_dv_o, bus.empty_o, bus.full_o, bus.overflow_o, bus.level_o, bus.tx_data_o},
        {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00});
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {bus.tx_dv_o, bus.empty_o, bus.level_o}, {1'b0, 1'b1, 5'd0});
    end

    // 2: single byte, dv two cycles after the push edge
    #1 bus.wr_en_i = 1'b1; bus.wr_data_i = 8'hA5;
    @(negedge clk);
    chk("single_lvl1", {bus.tx_dv_o, bus.level_o}, {1'b0, 5'd1});
    #1 bus.wr_en_i = 1'b0;
    @(negedge clk);
    chk("single_dv", {bus.tx_dv_o, bus.tx_data_o}, {1'b1, 8'hA5});
    #1 force_busy = 1'b1;
    @(negedge clk);
    chk("single_lvl0", {bus.tx_dv_o, bus.level_o, bus.empty_o}, {1'b0, 5'd0, 1'b1});
    repeat (100) @(negedge clk);
    chk("single_once", got.size(), 1);
    #1 force_busy = 1'b0;
    wait_idle();

    // 3: burst ordering with 50-cycle frames
    frame_len = 50;
    base      = got.size();
    gap_from  = cyc;
    chk_gap   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(i + 1);
      @(negedge clk);
      #1;
    end
    bus.wr_en_i = 1'b0;
    wait_items("burst_timeout", base + 5, 600);
    for (int i = 0; i < 5; i++)
      if (got.size() > base + i) chk($sformatf("burst_b%0d", i), got[base + i], 32'(i + 1));
    wait_idle();
    chk_gap = 1'b0;

    // 4: fill, overflow, set-over-clear priority, clear, then drain
    frame_len  = 4;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 15) chk("full16", {bus.full_o, bus.overflow_o, bus.level_o}, {1'b1, 1'b0, 5'd16});
      if (i == 16) chk("ovf17", {bus.full_o, bus.overflow_o, bus.level_o}, {1'b1, 1'b1, 5'd16});
      #1;
    end
    bus.wr_data_i = 8'hEE; bus.clr_ovf_i = 1'b1;
    @(negedge clk);
    chk("ovf_prio", {bus.overflow_o, bus.level_o}, {1'b1, 5'd16});
    #1 bus.wr_en_i = 1'b0;
    @(negedge clk);
    chk("ovf_clr", bus.overflow_o, 1'b0);
    #1 bus.clr_ovf_i = 1'b0;
    base       = got.size();
    force_busy = 1'b0;
    wait_items("drain_timeout", base + 16, 400);
    repeat (20) @(negedge clk);
    chk("drain_cnt", got.size(), base + 16);
    for (int i = 0; i < 16; i++)
      if (got.size() > base + i) chk($sformatf("drain_b%0d", i), got[base + i], 32'(8'h10 + i));
    wait_idle();

    // 5: push during the issue cycle at level 1
    force_busy  = 1'b1;
    bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h5A;
    @(negedge clk);
    #1 bus.wr_en_i = 1'b0;
    @(negedge clk);
    chk("pp_lvl1", bus.level_o, 5'd1);
    base = got.size();
    #1 force_busy = 1'b0;
    c = 0;
    while (!bus.tx_dv_o && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("pp_issue", bus.tx_dv_o, 1'b1);
    #1 bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h3C;
    @(negedge clk);
    chk("pp_lvl_hold", bus.level_o, 5'd1);
    #1 bus.wr_en_i = 1'b0;
    wait_items("pp_timeout", base + 2, 50);
    if (got.size() >= base + 2) chk("pp_order", {got[base], got[base + 1]}, {8'h5A, 8'h3C});
    wait_idle();

    // 6: reset while draining with four bytes buffered
    frame_len = 50;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(8'h41 + i);
      @(negedge clk);
      #1;
    end
    bus.wr_en_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_lvl4", {bus.tx_dv_o, bus.level_o}, {1'b0, 5'd4});
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {bus.tx_dv_o, bus.empty_o, bus.full_o, bus.overflow_o, bus.level_o, bus.tx_data_o},
        {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00});
    #1 rst = 1'b0;
    base = got.size();
    bus.wr_en_i = 1'b1; bus.wr_data_i = 8'h77;
    c = cyc;
    @(negedge clk);
    #1 bus.wr_en_i = 1'b0;
    wait_items("post_rst_timeout", base + 1, 10);
    if (got.size() > base) begin
      chk("post_rst_data", got[base], 8'h77);
      chk("post_rst_lat", dv_cyc[base] - c, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
